// File: rtl/fnv1a_stream_hasher_pkg.sv
// rtl/fnv1a_stream_hasher_pkg.sv - shared FNV-1a constants and FSM state encoding
// Purpose: constants and state type shared by the hasher top, its step helper
//          and the register interface.
// Ports:   none (package).
package fnv1a_stream_hasher_pkg;

  localparam logic [31:0] FNV_OFFSET_BASIS = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME        = 32'h01000193;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HASH = 2'd1,
    ST_DONE = 2'd2
  } hash_state_t;

endpackage

// File: rtl/fnv1a_stream_hasher_if.sv
// rtl/fnv1a_stream_hasher_if.sv - host, FIFO read port and result bundle for the hasher
// Purpose: groups the job request, FIFO fall-through read port and result/status
//          signals of the hasher.
// Ports (signals):
//   start, len, abort, hash_ack      host requests        (master -> slave)
//   fifo_empty, fifo_rdata           FIFO head of queue   (master -> slave)
//   fifo_rd_en                       FIFO pop strobe      (slave -> master)
//   busy, hash_valid, hash_out,
//   bytes_left                       result / status      (slave -> master)
interface fnv1a_stream_hasher_if #(
  parameter int DATASIZE  = 8,
  parameter int LEN_WIDTH = 16
);

  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic                 abort;
  logic                 fifo_empty;
  logic [DATASIZE-1:0]  fifo_rdata;
  logic                 fifo_rd_en;
  logic                 busy;
  logic                 hash_valid;
  logic                 hash_ack;
  logic [31:0]          hash_out;
  logic [LEN_WIDTH-1:0] bytes_left;

  modport master (
    output start, len, abort, fifo_empty, fifo_rdata, hash_ack,
    input  fifo_rd_en, busy, hash_valid, hash_out, bytes_left
  );

  modport slave (
    input  start, len, abort, fifo_empty, fifo_rdata, hash_ack,
    output fifo_rd_en, busy, hash_valid, hash_out, bytes_left
  );

endinterface

// File: rtl/fnv1a_stream_hasher_step.sv
// rtl/fnv1a_stream_hasher_step.sv - one combinational FNV-1a round
// Purpose: next_hash = (hash ^ data) * 0x01000193 mod 2^32.
// Ports:
//   hash       in  32  current hash
//   data       in  8   byte to absorb
//   next_hash  out 32  updated hash
module fnv1a_stream_hasher_step (
  input  logic [31:0] hash,
  input  logic [7:0]  data,
  output logic [31:0] next_hash
);

  logic [31:0] x;

  assign x = hash ^ {24'b0, data};

  // 0x01000193 = 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 2^0; shifts and adds keep
  // the round free of a hard multiplier.
  assign next_hash = (x << 24) + (x << 8) + (x << 7) + (x << 4) + (x << 1) + x;

endmodule

// File: rtl/fnv1a_stream_hasher.sv
// rtl/fnv1a_stream_hasher.sv - FNV-1a hasher over a byte stream from a fall-through FIFO
// Purpose: hashes `len` bytes popped from the FIFO head and holds the 32-bit
//          result for the register map until acknowledged.
// Ports:
//   clk    in   1   single clock shared with the FIFO read side
//   rst_n  in   1   asynchronous active-low reset
//   bus    slave    job request, FIFO read port and result/status signals
module fnv1a_stream_hasher
  import fnv1a_stream_hasher_pkg::*;
#(
  parameter int          DATASIZE     = 8,
  parameter int          LEN_WIDTH    = 16,
  parameter logic [31:0] OFFSET_BASIS = FNV_OFFSET_BASIS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fnv1a_stream_hasher_if.slave  bus
);

  hash_state_t          state_q, state_d;
  logic [31:0]          hash_q;
  logic [31:0]          hash_step;
  logic [LEN_WIDTH-1:0] bytes_left_q;
  logic [DATASIZE-1:0]  rd_byte;
  logic                 rd_en;
  logic                 load;

  assign rd_byte = bus.fifo_rdata;

  fnv1a_stream_hasher_step u_step (
    .hash      (hash_q),
    .data      (rd_byte[7:0]),
    .next_hash (hash_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort overrides everything, including a pop that would otherwise happen.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    load    = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            load    = 1'b1;
            state_d = (bus.len == '0) ? ST_DONE : ST_HASH;
          end
        end
        ST_HASH: begin
          if (!bus.fifo_empty) begin
            rd_en = 1'b1;
            if (bytes_left_q == LEN_WIDTH'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // A new start doubles as the acknowledge.
          if (bus.start) begin
            load    = 1'b1;
            state_d = (bus.len == '0) ? ST_DONE : ST_HASH;
          end else if (bus.hash_ack) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_q       <= OFFSET_BASIS;
      bytes_left_q <= '0;
    end else if (bus.abort) begin
      bytes_left_q <= '0;
    end else if (load) begin
      hash_q       <= OFFSET_BASIS;
      bytes_left_q <= bus.len;
    end else if (rd_en) begin
      hash_q       <= hash_step;
      bytes_left_q <= bytes_left_q - LEN_WIDTH'(1);
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.busy       = (state_q == ST_HASH);
  assign bus.hash_valid = (state_q == ST_DONE);
  assign bus.hash_out   = hash_q;
  assign bus.bytes_left = bytes_left_q;

endmodule

// File: tb/tb_fnv1a_stream_hasher.sv
// tb/tb_fnv1a_stream_hasher.sv - directed vector bench for fnv1a_stream_hasher
module tb_fnv1a_stream_hasher;

  typedef struct {
    logic [63:0] data;   // bytes right-justified, first byte most significant
    int          n;
    logic [31:0] hash;
    bit          stall;
  } vec_t;

  logic clk;
  logic rst_n;

  fnv1a_stream_hasher_if #(.DATASIZE(8), .LEN_WIDTH(16)) bus ();

  fnv1a_stream_hasher #(
    .DATASIZE     (8),
    .LEN_WIDTH    (16),
    .OFFSET_BASIS (32'h811C9DC5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Fall-through FIFO model.
  logic [7:0] mem [0:63];
  int         rptr = 0;
  int         wptr = 0;
  int         pop_cnt = 0;
  logic       stall = 1'b0;
  bit         stall_en = 1'b0;
  bit         flush = 1'b0;
  int         rd_viol = 0;

  int passed = 0;
  int total  = 0;

  assign bus.fifo_empty = (rptr == wptr) || stall;
  assign bus.fifo_rdata = mem[rptr[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (flush) begin
      rptr <= wptr;
    end else if (bus.fifo_rd_en) begin
      rptr    <= rptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  always @(negedge clk) begin
    stall = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    #1;
    if (bus.fifo_rd_en && (!bus.busy || bus.abort)) rd_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wptr[5:0]] = b;
    wptr++;
  endtask

  task automatic push_vec(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) push(d[8*(n-1-i) +: 8]);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Call at a negedge; start is seen at the next posedge (cycle 0).
  task automatic run_job(input int l, output int cyc, output logic [31:0] h, output int pops);
    int p0;
    p0        = pop_cnt;
    bus.start = 1'b1;
    bus.len   = 16'(l);
    cyc       = 0;
    do begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.hash_ack = 1'b0;
      cyc++;
    end while (!bus.hash_valid && cyc < 300);
    h    = bus.hash_out;
    pops = pop_cnt - p0;
  endtask

  task automatic ack(input string name);
    bus.hash_ack = 1'b1;
    @(negedge clk);
    bus.hash_ack = 1'b0;
    check(name, 32'(bus.hash_valid), 32'd0);
  endtask

  vec_t        vecs [8];
  int          cyc;
  int          pops;
  logic [31:0] h;

  initial begin
    vecs[0] = '{64'h0,                0, 32'h811C9DC5, 1'b0}; // ""
    vecs[1] = '{64'h61,               1, 32'hE40C292C, 1'b0}; // "a"
    vecs[2] = '{64'h62,               1, 32'hE70C2DE5, 1'b0}; // "b"
    vecs[3] = '{64'h666F,             2, 32'h6222E842, 1'b0}; // "fo"
    vecs[4] = '{64'h666F6F,           3, 32'hA9F37ED7, 1'b0}; // "foo"
    vecs[5] = '{64'h666F6F62,         4, 32'h3F5076EF, 1'b0}; // "foob"
    vecs[6] = '{64'h666F6F626172,     6, 32'hBF9CF968, 1'b1}; // "foobar"
    vecs[7] = '{64'h666F6F6261,       5, 32'h39AAA18A, 1'b1}; // "fooba"

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.abort    = 1'b0;
    bus.hash_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_hash_out",   bus.hash_out, 32'h811C9DC5);
    check("reset_bytes_left", 32'(bus.bytes_left), 32'd0);
    check("reset_busy",       32'(bus.busy), 32'd0);
    check("reset_hash_valid", 32'(bus.hash_valid), 32'd0);
    check("reset_rd_en",      32'(bus.fifo_rd_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: prefilled FIFO, or bytes trickling in with random stalls.
    for (int v = 0; v < 8; v++) begin
      push_vec(vecs[v].data, vecs[v].n);
      stall_en = vecs[v].stall;
      run_job(vecs[v].n, cyc, h, pops);
      stall_en = 1'b0;
      check($sformatf("vec%0d_valid", v), 32'(bus.hash_valid), 32'd1);
      check($sformatf("vec%0d_hash", v), h, vecs[v].hash);
      check($sformatf("vec%0d_pops", v), 32'(pops), 32'(vecs[v].n));
      if (!vecs[v].stall) check($sformatf("vec%0d_latency", v), 32'(cyc), 32'(vecs[v].n + 1));
      @(negedge clk);
      check($sformatf("vec%0d_hold", v), bus.hash_out, vecs[v].hash);
      ack($sformatf("vec%0d_ack", v));
    end

    // len=3 with 5 bytes queued, then start+ack together in DONE for the rest.
    push_vec(64'h666F6F666F, 5); // "foo" "fo"
    run_job(3, cyc, h, pops);
    check("split1_hash", h, 32'hA9F37ED7);
    check("split1_pops", 32'(pops), 32'd3);
    check("split1_left_in_fifo", 32'(wptr - rptr), 32'd2);
    bus.hash_ack = 1'b1;
    run_job(2, cyc, h, pops);
    check("split2_hash", h, 32'h6222E842);
    check("split2_pops", 32'(pops), 32'd2);
    check("split2_latency", 32'(cyc), 32'd3);
    ack("split2_ack");

    // Abort in cycle 2 of a len=6 job.
    push_vec(64'h666F6F626172, 6);
    bus.start = 1'b1;
    bus.len   = 16'd6;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.abort = 1'b1;
    #1;
    check("abort_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy",       32'(bus.busy), 32'd0);
    check("abort_bytes_left", 32'(bus.bytes_left), 32'd0);
    check("abort_hash_valid", 32'(bus.hash_valid), 32'd0);
    check("abort_hash_held",  bus.hash_out, 32'hE30C2799);
    check("abort_fifo_left",  32'(wptr - rptr), 32'd5);
    do_flush();

    // Starved job, ignored start in HASH, then async reset mid-job.
    push_vec(64'h666F, 2);
    bus.start = 1'b1;
    bus.len   = 16'd6;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    check("ignore_start_busy",  32'(bus.busy), 32'd1);
    check("ignore_start_left",  32'(bus.bytes_left), 32'd4);
    check("ignore_start_hash",  bus.hash_out, 32'h6222E842);
    push(8'h78);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_hash_out",   bus.hash_out, 32'h811C9DC5);
    check("midrst_bytes_left", 32'(bus.bytes_left), 32'd0);
    check("midrst_busy",       32'(bus.busy), 32'd0);
    check("midrst_hash_valid", 32'(bus.hash_valid), 32'd0);
    check("midrst_rd_en",      32'(bus.fifo_rd_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_fifo_untouched", 32'(wptr - rptr), 32'd1);
    do_flush();

    check("rd_en_outside_hash", 32'(rd_viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
